booth_seq_mult_ctrl: RTL and testbench

//   Sequential controller for a radix-2 Booth signed multiplier. Performs one Booth step per clock on a

---
 rtl/booth_pkg.sv | 26 ++
 rtl/booth_seq_mult_ctrl_if.sv | 26 ++
 rtl/booth_step_w.sv | 38 +++
 rtl/booth_seq_mult_ctrl.sv | 102 ++++++++++
 tb/tb_booth_seq_mult_ctrl.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types for the sequential radix-2 Booth multiplier: FSM states and
// the per-step Booth operation selected from the multiplier bit pair.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  // {Q[0], q_1}: 10 starts a run of ones (subtract), 01 ends one (add).
  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b10:   booth_decode = BOOTH_SUB;
      2'b01:   booth_decode = BOOTH_ADD;
      default: booth_decode = BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_seq_mult_ctrl_if.sv
// Operand and result channels of the sequential Booth multiplier.
// Both channels use valid/ready: a transfer happens on a rising edge where
// valid and ready are both high; the sender holds valid and data stable until then.
interface booth_seq_mult_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic               abort;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_result;
  logic               busy;

  modport master (
    output in_valid, in_a, in_b, abort, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, abort, out_ready,
    output in_ready, out_valid, out_result, busy
  );
endinterface

// File: rtl/booth_step_w.sv
// One combinational radix-2 Booth step: conditional add/subtract of M into A,
// then arithmetic right shift of {A, Q, q_1} by one bit.
module booth_step_w
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;
  booth_op_t      op;

  // One extra accumulator bit keeps -(-2^(WIDTH-1)) representable.
  assign m_ext = {m[WIDTH-1], m};
  assign op    = booth_decode(q[0], q_1);

  always_comb begin
    sum = a;
    case (op)
      BOOTH_ADD: sum = a + m_ext;
      BOOTH_SUB: sum = a - m_ext;
      default:   sum = a;
    endcase
  end

  assign a_next   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next   = {sum[0], q[WIDTH-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/booth_seq_mult_ctrl.sv
// Sequential radix-2 Booth signed multiplier: one Booth step per clock,
// operands in and product out over valid/ready channels.
module booth_seq_mult_ctrl
  import booth_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  booth_seq_mult_ctrl_if.slave  bus,
  output state_t                fsm_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             state;
  state_t             next_state;
  logic [WIDTH:0]     acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   mcand;
  logic               q_1;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     acc_next;
  logic [WIDTH-1:0]   mq_next;
  logic               q_1_next;
  logic               accept;
  logic               last_step;

  booth_step_w #(.WIDTH(WIDTH)) u_step (
    .a        (acc),
    .q        (mq),
    .q_1      (q_1),
    .m        (mcand),
    .a_next   (acc_next),
    .q_next   (mq_next),
    .q_1_next (q_1_next)
  );

  assign accept    = bus.in_valid & bus.in_ready;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.in_valid) next_state = RUN;
      RUN: begin
        if (bus.abort)      next_state = IDLE;
        else if (last_step) next_state = DONE;
      end
      DONE: begin
        if (bus.out_ready) next_state = bus.in_valid ? RUN : IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: bus.in_ready = 1'b1;
      RUN:  bus.busy = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  // Registers hold the finished product through DONE and beyond until the next load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      mq    <= '0;
      mcand <= '0;
      q_1   <= 1'b0;
      cnt   <= '0;
    end else if (accept) begin
      acc   <= '0;
      mq    <= bus.in_b;
      mcand <= bus.in_a;
      q_1   <= 1'b0;
      cnt   <= '0;
    end else if (state == RUN && !bus.abort) begin
      acc   <= acc_next;
      mq    <= mq_next;
      q_1   <= q_1_next;
      cnt   <= cnt + 1'b1;
    end
  end

  assign bus.out_result = {acc[WIDTH-1:0], mq};
  assign fsm_state      = state;

endmodule

// File: tb/tb_booth_seq_mult_ctrl.sv
// Directed and randomized checks of the sequential Booth multiplier:
// reset, latency, corner products, backpressure, abort and a product scoreboard.
module tb_booth_seq_mult_ctrl;
  import booth_pkg::*;

  localparam int W = 32;

  logic   clk;
  logic   rst_n;
  state_t fsm_state;
  int     checks;
  int     failures;
  logic [2*W-1:0] exp_q[$];

  booth_seq_mult_ctrl_if #(.WIDTH(W)) bus ();

  booth_seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = 32'd5;
    bus.in_b     = 32'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 4;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      if (fsm_state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
    end
    checks++;
    if (bus.out_result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.out_result); end
    bus.in_valid = 1'b0;
    rst_n        = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_no_accept busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_basic();
    int n;
    bus.out_ready = 1'b1;
    start_op(32'd7, -32'sd3);
    bus.in_a = 32'hDEAD_BEEF;
    bus.in_b = 32'h1234_5678;
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bus.busy); end
    wait_valid(n);
    checks += 2;
    if (n !== 32) begin failures++; $display("FAIL basic_latency got=%0d exp=32", n); end
    if (bus.out_result !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      failures++; $display("FAIL basic_result got=%h exp=ffffffffffffffeb", bus.out_result);
    end
    tick();
    checks += 2;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL basic_consumed got=%b exp=0", bus.out_valid); end
    if (bus.out_result !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      failures++; $display("FAIL basic_hold got=%h exp=ffffffffffffffeb", bus.out_result);
    end
  endtask

  task automatic test_corners();
    logic [W-1:0]   ta[6];
    logic [W-1:0]   tb_v[6];
    logic [2*W-1:0] te[6];
    int n;
    ta[0] = 32'h8000_0000; tb_v[0] = 32'h8000_0000; te[0] = 64'h4000_0000_0000_0000;
    ta[1] = 32'h8000_0000; tb_v[1] = 32'h0000_0001; te[1] = 64'hFFFF_FFFF_8000_0000;
    ta[2] = 32'h0000_0000; tb_v[2] = 32'h1234_5678; te[2] = 64'h0000_0000_0000_0000;
    ta[3] = 32'h7FFF_FFFF; tb_v[3] = 32'h7FFF_FFFF; te[3] = 64'h3FFF_FFFF_0000_0001;
    ta[4] = 32'hFFFF_FFFF; tb_v[4] = 32'hFFFF_FFFF; te[4] = 64'h0000_0000_0000_0001;
    ta[5] = 32'h7FFF_FFFF; tb_v[5] = 32'h8000_0000; te[5] = 64'hC000_0000_8000_0000;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start_op(ta[i], tb_v[i]);
      wait_valid(n);
      checks++;
      if (bus.out_result !== te[i] || n !== 32) begin
        failures++;
        $display("FAIL corner_%0d got=%h lat=%0d exp=%h lat=32", i, bus.out_result, n, te[i]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int n;
    bus.out_ready = 1'b0;
    start_op(32'd6, 32'd7);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks += 3;
      if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, bus.out_valid); end
      if (bus.out_result !== 64'd42) begin failures++; $display("FAIL bp_result cyc=%0d got=%h exp=2a", i, bus.out_result); end
      if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", i, bus.in_ready); end
    end
    bus.in_valid  = 1'b1;
    bus.in_a      = -32'sd5;
    bus.in_b      = 32'd9;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL bp_turn_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    checks += 2;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL bp_turn_busy got=%b exp=1", bus.busy); end
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL bp_turn_valid got=%b exp=0", bus.out_valid); end
    wait_valid(n);
    checks++;
    if (bus.out_result !== 64'hFFFF_FFFF_FFFF_FFD3 || n !== 32) begin
      failures++; $display("FAIL bp_second got=%h lat=%0d exp=ffffffffffffffd3 lat=32", bus.out_result, n);
    end
    tick();
  endtask

  task automatic test_abort();
    int n;
    int seen;
    bus.out_ready = 1'b1;
    start_op(32'd5, 32'd6);
    for (int i = 0; i < 10; i++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks += 2;
    if (fsm_state !== IDLE) begin failures++; $display("FAIL abort_state got=%0d exp=0", fsm_state); end
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL abort_no_valid got=%0d exp=0", seen); end
    // abort together with in_valid in IDLE must still accept
    bus.abort     = 1'b1;
    bus.out_ready = 1'b0;
    start_op(32'd3, 32'd4);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL abort_idle_accept got=%b exp=1", bus.busy); end
    wait_valid(n);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks += 2;
    if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL abort_done_valid got=%b exp=1", bus.out_valid); end
    if (bus.out_result !== 64'd12) begin failures++; $display("FAIL abort_next_result got=%h exp=c", bus.out_result); end
    bus.out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0]          a;
    logic [W-1:0]          b;
    logic signed [2*W-1:0] ea;
    logic signed [2*W-1:0] eb;
    logic [2*W-1:0]        expv;
    int                    n;
    bit                    done;
    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: b = 32'h8000_0000;
        2: a = 32'h7FFF_FFFF;
        3: b = 32'(-$urandom_range(1, 16));
        default: ;
      endcase
      ea = $signed(a);
      eb = $signed(b);
      exp_q.push_back(ea * eb);
      start_op(a, b);
      done = 1'b0;
      n = 0;
      while (!done && n < 300) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        #1;
        if (bus.out_valid && bus.out_ready) begin
          expv = exp_q.pop_front();
          checks++;
          if (bus.out_result !== expv) begin
            failures++;
            $display("FAIL rand_%0d a=%h b=%h got=%h exp=%h", i, a, b, bus.out_result, expv);
          end
          done = 1'b1;
        end
        tick();
        n++;
      end
      if (!done) begin
        checks++;
        failures++;
        $display("FAIL rand_timeout_%0d got=no_result exp=result", i);
        void'(exp_q.pop_front());
      end
    end
  endtask

  // sequence and final report
  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.abort     = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_corners();
    test_backpressure();
    test_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
